// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- iterative RV32M multiply / divide unit
//
// Computes the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU,
// REM, REMU) on magnitudes. It uses shift-add multiply and restoring divide,
// retiring STEP bits per clock, with a final sign-fix cycle.
//
// Timing, counted from the cycle in which start is sampled high:
//   - Normal operation: done pulses XLEN/STEP+2 cycles later.
//   - Divide-by-zero and signed-overflow divides skip the iterative phase.
//     They finish 2 cycles after start.
//
// Parameters
//   XLEN    operand / result width (even, >= 8)
//   STEP    bits retired per CALC cycle (1, 2 or 4; divides XLEN)
//
// Ports
//   clk     clock, all state changes on the rising edge
//   reset   synchronous active-high reset
//   start   operation request, accepted only in IDLE or DONE
//   funct3  RV32M operation select
//   srca    rs1: multiplicand / dividend
//   srcb    rs2: multiplier / divisor
//   flush   abort any in-flight operation (wins over start)
//   busy    high while iterating (CALC) or sign-fixing (FIX)
//   done    one-cycle pulse; result is valid
//   result  operation result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITER = XLEN / STEP;
    localparam int CW   = $clog2(ITER) + 1;
    localparam int PW   = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      op_reg;
    // acc_reg: product high half / partial remainder
    // lo_reg : multiplier bits being consumed / dividend turning into quotient
    // opd_reg: multiplicand magnitude / divisor magnitude
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] opd_reg;
    logic            neg_reg;   // negate product or quotient in FIX
    logic            negr_reg;  // negate remainder in FIX
    logic            busy_reg;
    logic            done_reg;
    logic [XLEN-1:0] result_reg;

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

    // ------------------------------------------------------------------
    // Operand decode at start: signedness, magnitudes, bypass cases
    // ------------------------------------------------------------------
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end // MULH
            3'b010:         begin a_signed = 1'b1; b_signed = 1'b0; end // MULHSU
            3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end // DIV, REM
            default:        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        a_neg    = a_signed & srca[XLEN-1];
        b_neg    = b_signed & srcb[XLEN-1];
        a_mag    = a_neg ? ((~srca) + XLEN'(1)) : srca;
        b_mag    = b_neg ? ((~srcb) + XLEN'(1)) : srcb;
        div_zero = funct3[2] && (srcb == '0);
        div_ovf  = funct3[2] && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
    end

    // ------------------------------------------------------------------
    // Iteration datapath: STEP chained single-bit stages for both the
    // shift-add multiplier and the restoring divider. Each stage reads the
    // previous stage's outputs by hierarchical reference so there is no
    // self-referencing vector in the chain.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_step
            logic [XLEN-1:0] m_hi_in;
            logic [XLEN-1:0] m_lo_in;
            logic [XLEN-1:0] d_rem_in;
            logic [XLEN-1:0] d_quo_in;
            logic [XLEN-1:0] m_hi_out;
            logic [XLEN-1:0] m_lo_out;
            logic [XLEN-1:0] d_rem_out;
            logic [XLEN-1:0] d_quo_out;
            logic [XLEN:0]   m_sum;
            logic [XLEN:0]   d_shift;
            logic            d_ge;
            logic [XLEN-1:0] d_sub;

            if (gi == 0) begin : g_first
                assign m_hi_in  = acc_reg;
                assign m_lo_in  = lo_reg;
                assign d_rem_in = acc_reg;
                assign d_quo_in = lo_reg;
            end else begin : g_chain
                assign m_hi_in  = g_step[gi-1].m_hi_out;
                assign m_lo_in  = g_step[gi-1].m_lo_out;
                assign d_rem_in = g_step[gi-1].d_rem_out;
                assign d_quo_in = g_step[gi-1].d_quo_out;
            end

            // Multiply: add multiplicand when the current multiplier bit is
            // set, then shift the 2*XLEN product right by one. The carry
            // ends up in the top bit.
            assign m_sum    = {1'b0, m_hi_in} + (m_lo_in[0] ? {1'b0, opd_reg} : '0);
            assign m_hi_out = m_sum[XLEN:1];
            assign m_lo_out = {m_sum[0], m_lo_in[XLEN-1:1]};

            // Divide: bring in the next dividend bit. Subtract the divisor
            // when it fits. The remainder always stays below the divisor, so
            // the low XLEN bits of the difference are exact.
            assign d_shift   = {d_rem_in, d_quo_in[XLEN-1]};
            assign d_ge      = d_shift >= {1'b0, opd_reg};
            assign d_sub     = d_shift[XLEN-1:0] - opd_reg;
            assign d_rem_out = d_ge ? d_sub : d_shift[XLEN-1:0];
            assign d_quo_out = {d_quo_in[XLEN-2:0], d_ge};
        end
    endgenerate

    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] lo_next;

    always_comb begin
        acc_next = g_step[STEP-1].m_hi_out;
        lo_next  = g_step[STEP-1].m_lo_out;
        if (op_reg[2]) begin
            acc_next = g_step[STEP-1].d_rem_out;
            lo_next  = g_step[STEP-1].d_quo_out;
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection (evaluated in FIX)
    // ------------------------------------------------------------------
    logic [PW-1:0]   prod_raw;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_value;

    always_comb begin
        prod_raw = {acc_reg, lo_reg};
        prod_fix = neg_reg ? ((~prod_raw) + PW'(1)) : prod_raw;
        quo_fix  = neg_reg ? ((~lo_reg) + XLEN'(1)) : lo_reg;
        rem_fix  = negr_reg ? ((~acc_reg) + XLEN'(1)) : acc_reg;
        if (op_reg[2]) begin
            fix_value = op_reg[1] ? rem_fix : quo_fix;
        end else if (op_reg[1:0] == 2'b00) begin
            fix_value = prod_fix[XLEN-1:0];
        end else begin
            fix_value = prod_fix[PW-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            acc_reg    <= '0;
            lo_reg     <= '0;
            opd_reg    <= '0;
            neg_reg    <= 1'b0;
            negr_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (flush) begin
            // Abort: drop any request and leave result untouched.
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg   <= funct3;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (!funct3[2]) begin
                            // Multiply: multiplier bits go in lo, product grows in acc
                            acc_reg   <= '0;
                            lo_reg    <= b_mag;
                            opd_reg   <= a_mag;
                            neg_reg   <= a_neg ^ b_neg;
                            negr_reg  <= 1'b0;
                            state_reg <= S_CALC;
                        end else if (div_zero) begin
                            // Quotient all ones, remainder = dividend (sign restored in FIX)
                            acc_reg   <= a_mag;
                            lo_reg    <= '1;
                            opd_reg   <= b_mag;
                            neg_reg   <= 1'b0;
                            negr_reg  <= a_neg;
                            state_reg <= S_FIX;
                        end else if (div_ovf) begin
                            // Quotient = dividend bit pattern, remainder = 0
                            acc_reg   <= '0;
                            lo_reg    <= srca;
                            opd_reg   <= b_mag;
                            neg_reg   <= 1'b0;
                            negr_reg  <= 1'b0;
                            state_reg <= S_FIX;
                        end else begin
                            acc_reg   <= '0;
                            lo_reg    <= a_mag;
                            opd_reg   <= b_mag;
                            neg_reg   <= a_neg ^ b_neg;
                            negr_reg  <= a_neg;
                            state_reg <= S_CALC;
                        end
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_reg <= acc_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(ITER - 1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_reg <= fix_value;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= S_DONE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter -- self-checking bench for muldiv_iter
//
// Two instances share operands, reset and flush:
//   - dut1: XLEN=32, STEP=1
//   - dut4: XLEN=32, STEP=4
// Each instance has its own start signal. Expected results come from a 64-bit
// arithmetic reference function. Expected latencies come from the operation
// class.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;

    localparam int N1 = 32;     // iterations at STEP=1
    localparam int N4 = 8;      // iterations at STEP=4
    localparam int MAXW = 200;  // cycle budget for any wait

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start4;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .funct3(funct3),
        .srca(srca), .srcb(srcb), .flush(flush),
        .busy(busy1), .done(done1), .result(result1)
    );

    muldiv_iter #(.XLEN(32), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .funct3(funct3),
        .srca(srca), .srcb(srcb), .flush(flush),
        .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input int iters);
        if (f3[2] && (b == 0)) return 2;
        if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
        return iters + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // One full operation on the chosen instance. Operands are scrambled after
    // acceptance; the result must not depend on them.
    task automatic run_op(input bit use4, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input string tag, output logic [31:0] got);
        logic [31:0] exp_r;
        int          exp_l;
        int          cyc;
        logic        d;
        exp_r  = ref_result(f3, a, b);
        exp_l  = ref_latency(f3, a, b, use4 ? N4 : N1);
        funct3 = f3;
        srca   = a;
        srcb   = b;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        funct3 = 3'($urandom);
        srca   = $urandom;
        srcb   = $urandom;
        cyc    = 1;
        d      = use4 ? done4 : done1;
        while (!d && cyc < MAXW) begin
            @(posedge clk); #1;
            cyc++;
            d = use4 ? done4 : done1;
        end
        got = use4 ? result4 : result1;
        check({tag, " result"}, got, exp_r);
        check({tag, " latency"}, 32'(cyc), 32'(exp_l));
        check({tag, " busy with done"}, 32'(use4 ? busy4 : busy1), 32'd0);
        @(posedge clk); #1;
        check({tag, " done width"}, 32'(use4 ? done4 : done1), 32'd0);
        $display("op %-10s step%0d f3=%0d a=%08h b=%08h -> %08h (exp %08h) latency %0d (exp %0d)",
                 tag, use4 ? 4 : 1, f3, a, b, got, exp_r, cyc, exp_l);
    endtask

    typedef struct {
        bit          use4;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } dir_t;

    dir_t dirs [15] = '{
        '{1'b0, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{1'b0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{1'b0, 3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{1'b0, 3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{1'b0, 3'd5, 32'd100,        32'd7,         32'd14},
        '{1'b0, 3'd7, 32'd100,        32'd7,         32'd2},
        '{1'b0, 3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{1'b0, 3'd6, 32'd5,          32'd0,         32'd5},
        '{1'b0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{1'b0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{1'b0, 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{1'b0, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{1'b0, 3'd7, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
        '{1'b1, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{1'b1, 3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] prev;
        logic [31:0] a_a, a_b, b_a, b_b;
        int          cyc;
        int          ndone;
        bit          use4;
        logic [2:0]  f3;

        reset  = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        srca   = 32'd0;
        srcb   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset done1", 32'(done1), 32'd0);
        check("reset result1", result1, 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset done4", 32'(done4), 32'd0);
        check("reset result4", result4, 32'd0);
        $display("reset: busy1=%0d done1=%0d result1=%08h busy4=%0d done4=%0d result4=%08h",
                 busy1, done1, result1, busy4, done4, result4);
        reset = 1'b0;

        // Directed cases; the first start arrives in the first cycle after reset
        foreach (dirs[i]) begin
            run_op(dirs[i].use4, dirs[i].f3, dirs[i].a, dirs[i].b, $sformatf("dir%0d", i), got);
            check($sformatf("dir%0d constant", i), got, dirs[i].e);
        end

        // Randomized operations on both step sizes
        for (int i = 0; i < 80; i++) begin
            use4 = (i % 4) == 3;
            f3   = 3'($urandom_range(0, 7));
            run_op(use4, f3, pick_operand(), pick_operand(), $sformatf("rnd%0d", i), got);
        end

        // Flush 10 cycles into a DIV, with a simultaneous start that must be dropped
        prev   = result1;
        funct3 = 3'd4;
        srca   = 32'h1234_5678;
        srcb   = 32'd3;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush  = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        start1 = 1'b0;
        check("flush busy", 32'(busy1), 32'd0);
        check("flush done", 32'(done1), 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done1) ndone++;
            @(posedge clk); #1;
        end
        check("flush no done", 32'(ndone), 32'd0);
        check("flush result held", result1, prev);
        $display("flush: busy=%0d done pulses=%0d result=%08h (held %08h)", busy1, ndone, result1, prev);
        run_op(1'b0, 3'd4, 32'h1234_5678, 32'd3, "postflush", got);

        // Back-to-back: start held through DONE; second op enters CALC directly
        a_a    = $urandom;
        a_b    = $urandom;
        b_a    = $urandom;
        b_b    = $urandom | 32'h1;
        funct3 = 3'd3;
        srca   = a_a;
        srcb   = a_b;
        start1 = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'd5;
        srca   = b_a;
        srcb   = b_b;
        cyc    = 1;
        while (!done1 && cyc < MAXW) begin @(posedge clk); #1; cyc++; end
        check("b2b first latency", 32'(cyc), 32'(N1 + 2));
        check("b2b first result", result1, ref_result(3'd3, a_a, a_b));
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b direct calc", 32'(busy1), 32'd1);
        cyc = 1;
        while (!done1 && cyc < MAXW) begin @(posedge clk); #1; cyc++; end
        check("b2b spacing", 32'(cyc), 32'(N1 + 2));
        check("b2b second result", result1, ref_result(3'd5, b_a, b_b));
        check("b2b busy with done", 32'(busy1), 32'd0);
        $display("b2b: MULHU %08h*%08h then DIVU %08h/%08h -> %08h, spacing %0d",
                 a_a, a_b, b_a, b_b, result1, cyc);
        @(posedge clk); #1;

        // Reset in the middle of a STEP=4 computation
        funct3 = 3'd0;
        srca   = $urandom;
        srcb   = $urandom;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midreset busy before", 32'(busy4), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset busy4", 32'(busy4), 32'd0);
        check("midreset done4", 32'(done4), 32'd0);
        check("midreset result4", result4, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done4) ndone++;
            @(posedge clk); #1;
        end
        check("midreset no done", 32'(ndone), 32'd0);
        $display("midreset: busy4=%0d done pulses=%0d result4=%08h", busy4, ndone, result4);
        run_op(1'b1, 3'd6, 32'hFFFF_FF9C, 32'd7, "postreset", got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
